unified_buffer_stream: RTL
==========================

Name: unified_buffer_stream

Overview:
Parametrised on-chip activation/result buffer for the N x N systolic array. Accepts N-word result rows from the accumulators through a valid/ready write port, with explicit or auto-incrementing addressing. Streams bursts of N-word rows to the input-setup stage through a valid/ready read port. Clears itself after reset with a hardware sweep, so no per-word asynchronous reset of the array is needed.

Parameters:
DATA_W, 32, width of one word
N, 2, lanes: words per row, equal to the systolic array dimension
DEPTH, 64, total words; must be a multiple of N
ADDR_W, $clog2(DEPTH), word address width
LEN_W, 8, width of the burst length field

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
wr_valid  in  1  write row offered
wr_ready  out  1  write row accepted this cycle when high together with wr_valid
wr_auto  in  1  1: use internal wr_ptr; 0: use wr_addr
wr_addr  in  ADDR_W  start word address of the row
wr_data  in  N*DATA_W  row data; lane i occupies bits [i*DATA_W +: DATA_W]
wr_ptr  out  ADDR_W  next auto-write address
rd_start  in  1  burst request
rd_addr  in  ADDR_W  burst start word address
rd_len  in  LEN_W  number of rows in the burst; 0 is treated as 1
rd_busy  out  1  clear sweep or read burst in progress
rd_valid  out  1  rd_data holds a valid row
rd_ready  in  1  consumer accepts the row
rd_data  out  N*DATA_W  output row
rd_last  out  1  marks the final row of a burst
init_done  out  1  clear sweep finished

Behaviour:
- Reset (async assert): state goes to CLEAR; clear counter = 0; wr_ptr = 0. All other outputs reset to 0: wr_ready, rd_busy, rd_valid, rd_last, rd_data, init_done.
- FSM states:
  - CLEAR: one row of N zero words is written per cycle at clear counter*N. Lasts DEPTH/N cycles, then moves to IDLE and sets init_done = 1. While in CLEAR: wr_ready = 0, rd_busy = 1, rd_start is ignored.
  - IDLE: rd_busy = 0. rd_start = 1 captures rd_addr and rd_len into the read pointer and remaining-row count, then moves to READ. rd_busy goes high in the next cycle.
  - READ: when the output register is empty, or holds a row that is being accepted (rd_valid & rd_ready), the row at the read pointer is loaded into rd_data. rd_valid = 1 the cycle after the load.
    - Read pointer advances by N; remaining count decrements.
    - rd_last = 1 together with the final row.
    - Once the final row is accepted: rd_valid = 0, rd_busy = 0, back to IDLE.
    - First row appears 2 cycles after the rd_start cycle.
    - With rd_ready held at 1, one row is delivered per cycle.
- Backpressure: while rd_valid = 1 and rd_ready = 0, rd_data and rd_last are held stable and the read pointer does not advance.
- rd_start outside IDLE is ignored; there is no queueing.
- Write port:
  - wr_ready = 1 in every state except CLEAR.
  - On wr_valid & wr_ready, the N words are written at address A+i (mod DEPTH), where A is wr_ptr if wr_auto = 1, otherwise wr_addr.
  - Every accepted write sets wr_ptr to A+N (mod DEPTH), including explicit-address writes.
- Address arithmetic: all word addresses wrap mod DEPTH, including misaligned rows that straddle the top of memory. A row read at DEPTH-1 returns words DEPTH-1, 0, ..., N-2.
- Simultaneous write and read of the same word in one cycle: the read returns the old contents (read-first). The new data is visible to the next load.
- Writes are allowed during a READ burst.
- Reset asserted mid-burst or mid-clear: the burst is aborted, outputs return to their reset values, and the clear sweep restarts.
- Memory contents are defined only after init_done = 1.

Decomposition:
- Shared package tpu_pkg: DATA_W, N, and the FSM state enum ub_state_t {UB_CLEAR, UB_IDLE, UB_READ}.
- One sub-module, ub_row_mem: N-wide multi-word write plus N-wide read-first read with modulo-DEPTH addressing. The top level holds the FSM, pointers and handshakes.

Test Plan:
- Reset, then idle: init_done rises exactly 32 cycles after reset release (DEPTH=64, N=2). A burst of 32 rows from 0 returns all zeros; rd_last is set only on row 31.
- Auto write of rows {11,12}, {21,22} from wr_ptr = 0, then rd_start with addr=0, len=2: rows {11,12} then {21,22}. rd_valid first appears 2 cycles after rd_start; rd_last is set on the second row; wr_ptr = 4.
- Explicit write of {7,8} at address 63: mem[63] = 7, mem[0] = 8. A read at 63 with len=1 returns {7,8}, and wr_ptr = 1.
- Burst addr=0, len=3 with rd_ready toggling 1,0,0,1,1: each row is held stable while stalled; exactly 3 handshakes occur, with no duplicated or skipped rows.
- Same cycle: write {5,6} at address 4 and the read pointer loading address 4. The loaded row holds the old contents; a following read at address 4 returns {5,6}.
- Reset pulse during a burst (row 1 of 4): rd_valid drops to 0 immediately, the sweep reruns, and previously written data reads back as zero.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array datapath.
//   DATA_W     : default word width
//   N          : default lane count (systolic array dimension)
//   ub_state_t : unified-buffer controller states
//   wrap_addr  : modulo address helper used by buffer and controller
package tpu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned N      = 2;

   typedef enum logic [1:0] {
      UB_CLEAR,
      UB_IDLE,
      UB_READ
   } ub_state_t;

   // (base + off) mod depth; keeps misaligned rows wrapping across the top of memory.
   function automatic int unsigned wrap_addr(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned depth);
      return (base + off) % depth;
   endfunction

endpackage

// File: rtl/ub_row_mem.sv
// Row-wide word memory for the unified buffer.
// One N-word write per cycle and one combinational N-word read, both with word
// addresses wrapping mod DEPTH. The read is asynchronous, so a consumer that
// registers rd_data on the same edge as a write sees the old contents.
//   clk     : clock
//   wr_en   : write the row at wr_addr
//   wr_addr : start word address of the written row
//   wr_data : row data, lane i at [i*DATA_W +: DATA_W]
//   rd_addr : start word address of the read row
//   rd_data : row at rd_addr, lane i at [i*DATA_W +: DATA_W]
module ub_row_mem #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned N      = 2,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [N*DATA_W-1:0]   wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [N*DATA_W-1:0]   rd_data
);
   import tpu_pkg::*;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned i = 0; i < N; i++) begin
            mem[ADDR_W'(wrap_addr(32'(wr_addr), i, DEPTH))] <= wr_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         rd_data[i*DATA_W +: DATA_W] = mem[ADDR_W'(wrap_addr(32'(rd_addr), i, DEPTH))];
      end
   end

endmodule

// File: rtl/unified_buffer_stream.sv
// Unified activation/result buffer for the N x N systolic array.
// Accepts N-word result rows on a valid/ready write port (auto-increment or
// explicit address) and streams bursts of N-word rows on a valid/ready read
// port. After reset a hardware sweep zeroes the array one row per cycle.
//   clk, reset          : clock, asynchronous active-high reset
//   wr_valid/wr_ready   : write handshake; wr_ready low only during the sweep
//   wr_auto             : 1 writes at wr_ptr, 0 writes at wr_addr
//   wr_addr, wr_data    : explicit row address and row data
//   wr_ptr              : next auto-write address (follows every accepted write)
//   rd_start, rd_addr,
//   rd_len              : burst request, start address, row count (0 means 1)
//   rd_busy             : sweep or burst in progress
//   rd_valid/rd_ready   : read handshake; rd_data/rd_last held while stalled
//   rd_data, rd_last    : output row and final-row marker
//   init_done           : sweep finished, memory contents defined
module unified_buffer_stream #(
   parameter int unsigned DATA_W = tpu_pkg::DATA_W,
   parameter int unsigned N      = tpu_pkg::N,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = $clog2(DEPTH),
   parameter int unsigned LEN_W  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic                  wr_auto,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [N*DATA_W-1:0]   wr_data,
   output logic [ADDR_W-1:0]     wr_ptr,
   input  logic                  rd_start,
   input  logic [ADDR_W-1:0]     rd_addr,
   input  logic [LEN_W-1:0]      rd_len,
   output logic                  rd_busy,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [N*DATA_W-1:0]   rd_data,
   output logic                  rd_last,
   output logic                  init_done
);
   import tpu_pkg::*;

   localparam int unsigned ROWS = DEPTH / N;

   ub_state_t state_q, state_d;

   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [LEN_W-1:0]    remain_q, remain_d;
   logic                rd_valid_q, rd_valid_d;
   logic                rd_last_q, rd_last_d;
   logic [N*DATA_W-1:0] rd_data_q, rd_data_d;
   logic                wr_ready_q, wr_ready_d;
   logic                rd_busy_q, rd_busy_d;
   logic                init_done_q, init_done_d;

   logic                clear_last;
   logic                load;
   logic                final_accept;
   logic                wr_fire;
   logic [ADDR_W-1:0]   wr_base;

   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [N*DATA_W-1:0] mem_wdata;
   logic [N*DATA_W-1:0] mem_rdata;

   assign clear_last   = (32'(clr_cnt_q) == ROWS - 1);
   // Load when the output register is free or being drained this cycle.
   assign load         = (state_q == UB_READ) && (remain_q != '0) && (!rd_valid_q || rd_ready);
   assign final_accept = rd_valid_q && rd_ready && rd_last_q;
   assign wr_fire      = wr_valid && wr_ready_q;
   assign wr_base      = wr_auto ? wr_ptr_q : wr_addr;

   // The sweep owns the write port; wr_ready is low then, so no arbitration needed.
   assign mem_we    = (state_q == UB_CLEAR) || wr_fire;
   assign mem_waddr = (state_q == UB_CLEAR) ? ADDR_W'(32'(clr_cnt_q) * N) : wr_base;
   assign mem_wdata = (state_q == UB_CLEAR) ? '0 : wr_data;

   ub_row_mem #(
      .DATA_W (DATA_W),
      .N      (N),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_addr (mem_waddr),
      .wr_data (mem_wdata),
      .rd_addr (rd_ptr_q),
      .rd_data (mem_rdata)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= UB_CLEAR;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         UB_CLEAR: if (clear_last)   state_d = UB_IDLE;
         UB_IDLE:  if (rd_start)     state_d = UB_READ;
         UB_READ:  if (final_accept) state_d = UB_IDLE;
         default:                    state_d = UB_CLEAR;
      endcase
   end

   // Outputs and datapath next values
   always_comb begin
      clr_cnt_d   = clr_cnt_q;
      rd_ptr_d    = rd_ptr_q;
      remain_d    = remain_q;
      wr_ptr_d    = wr_ptr_q;
      rd_valid_d  = rd_valid_q;
      rd_last_d   = rd_last_q;
      rd_data_d   = rd_data_q;
      wr_ready_d  = (state_d != UB_CLEAR);
      rd_busy_d   = (state_d != UB_IDLE);
      init_done_d = init_done_q;

      if (state_q == UB_CLEAR) begin
         clr_cnt_d = clear_last ? '0 : clr_cnt_q + 1'b1;
         if (clear_last) init_done_d = 1'b1;
      end

      if (state_q == UB_IDLE && rd_start) begin
         rd_ptr_d = rd_addr;
         remain_d = (rd_len == '0) ? LEN_W'(1) : rd_len;
      end

      if (load) begin
         rd_data_d  = mem_rdata;
         rd_valid_d = 1'b1;
         rd_last_d  = (remain_q == LEN_W'(1));
         rd_ptr_d   = ADDR_W'(wrap_addr(32'(rd_ptr_q), N, DEPTH));
         remain_d   = remain_q - 1'b1;
      end else if (rd_valid_q && rd_ready) begin
         rd_valid_d = 1'b0;
         rd_last_d  = 1'b0;
      end

      if (wr_fire) begin
         wr_ptr_d = ADDR_W'(wrap_addr(32'(wr_base), N, DEPTH));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clr_cnt_q   <= '0;
         rd_ptr_q    <= '0;
         remain_q    <= '0;
         wr_ptr_q    <= '0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_data_q   <= '0;
         wr_ready_q  <= 1'b0;
         rd_busy_q   <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         clr_cnt_q   <= clr_cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         remain_q    <= remain_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_valid_q  <= rd_valid_d;
         rd_last_q   <= rd_last_d;
         rd_data_q   <= rd_data_d;
         wr_ready_q  <= wr_ready_d;
         rd_busy_q   <= rd_busy_d;
         init_done_q <= init_done_d;
      end
   end

   assign wr_ready  = wr_ready_q;
   assign wr_ptr    = wr_ptr_q;
   assign rd_busy   = rd_busy_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign rd_last   = rd_last_q;
   assign init_done = init_done_q;

endmodule
